// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: fetch port, load/store port and the memory-side signals.
// The arbiter uses the slave modport; requesters and the memory model use master.
interface mem_arbiter_if;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_ack;
    logic        d_err;
    logic [63:0] d_rdata;

    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wr;
    logic [63:0] mem_rdata;

    logic        busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ack, i_rdata, d_ack, d_err, d_rdata, mem_addr, mem_wdata, mem_wr, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_err, d_rdata, mem_addr, mem_wdata, mem_wr, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single 64-bit data memory between instruction fetch and load/store.
// Data port has fixed priority; a starvation counter lets fetch win after STARVE_MAX losses.
module mem_arbiter #(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    localparam logic [2:0] L_LAT    = 3'(RD_LAT);
    localparam logic [3:0] L_STARVE = 4'(STARVE_MAX);

    state_t      r_state;
    owner_t      r_owner;
    logic [2:0]  r_off;
    logic        r_we;
    logic [2:0]  r_lat;
    logic [3:0]  r_starve;
    logic        r_i_ack;
    logic        r_d_ack;
    logic        r_d_err;
    logic        r_mem_wr;
    logic [31:0] r_i_rdata;
    logic [63:0] r_d_rdata;
    logic [63:0] r_mem_addr;
    logic [63:0] r_mem_wdata;

    logic        w_grant_d;
    logic [63:0] w_sel_addr;
    logic        w_mis;

    assign w_grant_d  = bus.d_req & ~(bus.i_req & (r_starve == L_STARVE));
    assign w_sel_addr = w_grant_d ? bus.d_addr : bus.i_addr;
    // Only the data port can be misaligned; fetch addresses legitimately have bit 2 set.
    assign w_mis      = (r_owner == OWN_DATA) && (r_off != 3'b000);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_owner     <= OWN_FETCH;
            r_off       <= '0;
            r_we        <= 1'b0;
            r_lat       <= '0;
            r_starve    <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_d_err     <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_i_ack  <= 1'b0;
            r_d_ack  <= 1'b0;
            r_d_err  <= 1'b0;
            r_mem_wr <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.i_req && w_grant_d) begin
                        if (r_starve != L_STARVE) r_starve <= r_starve + 4'd1;
                    end else begin
                        r_starve <= '0;
                    end
                    if (bus.i_req || bus.d_req) begin
                        r_owner    <= w_grant_d ? OWN_DATA : OWN_FETCH;
                        r_off      <= w_sel_addr[2:0];
                        r_we       <= w_grant_d & bus.d_we;
                        r_mem_addr <= {w_sel_addr[63:3], 3'b000};
                        if (w_grant_d) r_mem_wdata <= bus.d_wdata;
                        r_mem_wr   <= w_grant_d & bus.d_we & (bus.d_addr[2:0] == 3'b000);
                        r_lat      <= '0;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_we) begin
                        r_d_ack <= 1'b1;
                        r_d_err <= w_mis;
                        r_state <= RESP;
                    end else if (r_lat == L_LAT) begin
                        if (r_owner == OWN_DATA) begin
                            r_d_ack <= 1'b1;
                            r_d_err <= w_mis;
                            if (!w_mis) r_d_rdata <= bus.mem_rdata;
                        end else begin
                            r_i_ack   <= 1'b1;
                            r_i_rdata <= r_off[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
                        end
                        r_state <= RESP;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.i_ack     = r_i_ack;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_ack     = r_d_ack;
    assign bus.d_err     = r_d_err;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-timeline model with its own memory image.
module tb_mem_arbiter;
    localparam int unsigned LAT  = 2;
    localparam int unsigned SMAX = 4;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.RD_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] init_word(input int i);
        if (i == 32) return 64'hAAAABBBB_11112222;
        return {32'(i) ^ 32'h5A5A_0000, ~32'(i * 7)};
    endfunction

    // Memory device: RD_LAT-stage read pipeline, write on mem_wr.
    logic [63:0] mem [64];
    logic [63:0] rd_pipe [LAT];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        for (int k = 0; k < int'(LAT); k++) rd_pipe[k] <= '0;
        forever begin
            @(posedge clk);
            if (bus.mem_wr) mem[bus.mem_addr[8:3]] <= bus.mem_wdata;
            rd_pipe[0] <= mem[bus.mem_addr[8:3]];
            for (int k = 1; k < int'(LAT); k++) rd_pipe[k] <= rd_pipe[k-1];
        end
    end
    assign bus.mem_rdata = rd_pipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    task automatic chkb(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] ref_mem [64];
    int unsigned m_ph, m_len, m_starve;
    bit          m_own_d, m_we, m_mis;
    logic [63:0] m_addr, e_maddr, e_mwdata, e_drdata;
    logic [31:0] e_irdata;
    bit          s_ireq, s_dreq, s_dwe;
    logic [63:0] s_iaddr, s_daddr, s_dwdata;

    task automatic model_reset();
        m_ph = 0; m_len = 1; m_starve = 0;
        m_own_d = 0; m_we = 0; m_mis = 0;
        e_maddr = '0; e_mwdata = '0; e_drdata = '0; e_irdata = '0;
    endtask

    task automatic model_check();
        bit resp;
        resp = (m_ph != 0) && (m_ph == m_len + 1);
        chkb("busy",   bus.busy,   m_ph != 0);
        chkb("mem_wr", bus.mem_wr, m_ph == 1 && m_we && !m_mis);
        chkb("i_ack",  bus.i_ack,  resp && !m_own_d);
        chkb("d_ack",  bus.d_ack,  resp && m_own_d);
        chkb("d_err",  bus.d_err,  resp && m_own_d && m_mis);
        chk("i_rdata",   64'(bus.i_rdata), 64'(e_irdata));
        chk("d_rdata",   bus.d_rdata,   e_drdata);
        chk("mem_addr",  bus.mem_addr,  e_maddr);
        chk("mem_wdata", bus.mem_wdata, e_mwdata);
    endtask

    initial begin : model
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                model_reset();
                #1;
                model_check();
            end else begin
                s_ireq = bus.i_req; s_iaddr = bus.i_addr;
                s_dreq = bus.d_req; s_dwe = bus.d_we;
                s_daddr = bus.d_addr; s_dwdata = bus.d_wdata;
                #1;
                if (m_ph == 0) begin
                    if (s_ireq || s_dreq) begin
                        m_own_d  = s_dreq && !(s_ireq && m_starve == SMAX);
                        m_starve = (s_ireq && m_own_d) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
                        m_addr   = m_own_d ? s_daddr : s_iaddr;
                        m_we     = m_own_d && s_dwe;
                        m_mis    = m_own_d && (m_addr[2:0] != 3'b000);
                        m_len    = m_we ? 1 : LAT + 1;
                        m_ph     = 1;
                        e_maddr  = {m_addr[63:3], 3'b000};
                        if (m_own_d) e_mwdata = s_dwdata;
                        if (m_we && !m_mis) ref_mem[m_addr[8:3]] = s_dwdata;
                    end else begin
                        m_starve = 0;
                    end
                end else if (m_ph == m_len + 1) begin
                    m_ph = 0;
                end else begin
                    m_ph++;
                    if (m_ph == m_len + 1 && !m_we) begin
                        if (!m_own_d)
                            e_irdata = m_addr[2] ? ref_mem[m_addr[8:3]][63:32] : ref_mem[m_addr[8:3]][31:0];
                        else if (!m_mis)
                            e_drdata = ref_mem[m_addr[8:3]];
                    end
                end
                model_check();
            end
        end
    end

    // ---------------- directed helpers ----------------
    // Starts a request in cycle 0 (current negedge) and observes cycles 1..LAT+6.
    task automatic txn(input bit is_d, input bit we, input logic [63:0] addr,
                       input logic [63:0] wdata, input int drop_at,
                       output int ack_cyc, output int ack_cnt, output int err_cnt,
                       output bit err_at_ack, output int wr_mask, output bit stable,
                       output logic [63:0] rdata);
        ack_cyc = -1; ack_cnt = 0; err_cnt = 0; err_at_ack = 0;
        wr_mask = 0; stable = 1; rdata = '0;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        for (int c = 1; c <= int'(LAT) + 6; c++) begin
            @(negedge clk);
            if (c == drop_at) begin bus.d_req = 1'b0; bus.i_req = 1'b0; end
            if (bus.mem_wr) wr_mask |= (1 << c);
            if (c <= int'(LAT) + 1 && bus.mem_addr != {addr[63:3], 3'b000}) stable = 0;
            if (bus.d_err) err_cnt++;
            if (is_d ? bus.d_ack : bus.i_ack) begin
                ack_cnt++;
                if (ack_cyc < 0) begin
                    ack_cyc    = c;
                    err_at_ack = bus.d_err;
                    rdata      = is_d ? bus.d_rdata : {32'd0, bus.i_rdata};
                end
                bus.d_req = 1'b0; bus.i_req = 1'b0;
            end
        end
    endtask

    task automatic chk_zero(input string pfx);
        chkb({pfx, "_busy"},   bus.busy,   1'b0);
        chkb({pfx, "_mem_wr"}, bus.mem_wr, 1'b0);
        chkb({pfx, "_i_ack"},  bus.i_ack,  1'b0);
        chkb({pfx, "_d_ack"},  bus.d_ack,  1'b0);
        chkb({pfx, "_d_err"},  bus.d_err,  1'b0);
        chk({pfx, "_i_rdata"},   64'(bus.i_rdata), 64'd0);
        chk({pfx, "_d_rdata"},   bus.d_rdata,   64'd0);
        chk({pfx, "_mem_addr"},  bus.mem_addr,  64'd0);
        chk({pfx, "_mem_wdata"}, bus.mem_wdata, 64'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "bench timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        int          ack_cyc, ack_cnt, err_cnt, wr_mask, acks, grants, b2b;
        bit          err_at, stable, prev, cur, gen;
        logic [63:0] rd;
        logic [9:0]  order;

        reset = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;

        // Fetch upper and lower halves of the word at 0x100, starting on the first cycle out of reset.
        txn(0, 0, 64'h104, '0, 0, ack_cyc, ack_cnt, err_cnt, err_at, wr_mask, stable, rd);
        chk("fetch_hi_ackcyc", 64'(ack_cyc), 64'(LAT + 2));
        chk("fetch_hi_acks",   64'(ack_cnt), 64'd1);
        chk("fetch_hi_data",   rd, 64'h0000_0000_AAAA_BBBB);
        txn(0, 0, 64'h100, '0, 0, ack_cyc, ack_cnt, err_cnt, err_at, wr_mask, stable, rd);
        chk("fetch_lo_data",   rd, 64'h0000_0000_1111_2222);

        // Store then load back.
        txn(1, 1, 64'h40, 64'hDEADBEEF_CAFEF00D, 0, ack_cyc, ack_cnt, err_cnt, err_at, wr_mask, stable, rd);
        chk("store_wr_cycles", 64'(wr_mask), 64'd2);
        chk("store_ackcyc",    64'(ack_cyc), 64'd2);
        chk("store_acks",      64'(ack_cnt), 64'd1);
        txn(1, 0, 64'h40, '0, 0, ack_cyc, ack_cnt, err_cnt, err_at, wr_mask, stable, rd);
        chk("load_ackcyc",     64'(ack_cyc), 64'(LAT + 2));
        chk("load_data",       rd, 64'hDEADBEEF_CAFEF00D);

        // Misaligned store: no write, err only alongside the ack.
        txn(1, 1, 64'h43, 64'h1234_5678_9ABC_DEF0, 0, ack_cyc, ack_cnt, err_cnt, err_at, wr_mask, stable, rd);
        chk("mis_wr_cycles",  64'(wr_mask), 64'd0);
        chk("mis_ackcyc",     64'(ack_cyc), 64'd2);
        chkb("mis_err_at_ack", err_at, 1'b1);
        chk("mis_err_cycles", 64'(err_cnt), 64'd1);
        chk("mis_acks",       64'(ack_cnt), 64'd1);

        // Load whose request drops in cycle 2 still completes.
        txn(1, 0, 64'h80, '0, 2, ack_cyc, ack_cnt, err_cnt, err_at, wr_mask, stable, rd);
        chk("drop_ackcyc",    64'(ack_cyc), 64'(LAT + 2));
        chkb("drop_addr_stable", stable, 1'b1);
        chk("drop_data",      rd, init_word(16));

        // Reset in the middle of a read clears everything immediately.
        bus.i_req = 1'b1; bus.i_addr = 64'h108;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_zero("midrst");
        bus.i_req = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.i_ack || bus.d_ack) acks++;
        end
        chk("midrst_no_ack", 64'(acks), 64'd0);
        reset = 1'b1;
        txn(0, 0, 64'h108, '0, 0, ack_cyc, ack_cnt, err_cnt, err_at, wr_mask, stable, rd);
        chk("postrst_ackcyc", 64'(ack_cyc), 64'(LAT + 2));
        chk("postrst_data",   rd, 64'(init_word(33)) & 64'hFFFF_FFFF);

        // Both ports held: fetch wins every (SMAX+1)-th grant.
        bus.i_req = 1'b1; bus.i_addr = 64'h104;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h40;
        order = '0; grants = 0; prev = 0; b2b = 0;
        for (int c = 0; c < 10 * (int'(LAT) + 3) + 10 && grants < 10; c++) begin
            @(negedge clk);
            cur = bus.i_ack | bus.d_ack;
            if (cur && prev) b2b++;
            if (bus.i_ack) begin order[grants] = 1'b1; grants++; end
            else if (bus.d_ack) grants++;
            prev = cur;
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        chk("starve_grants", 64'(grants), 64'd10);
        chk("starve_order",  64'(order), 64'h210);
        chk("starve_b2b",    64'(b2b), 64'd0);
        repeat (2) @(negedge clk);

        // Random traffic; the model checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            gen = (n < 2950);
            if (!bus.i_req || bus.i_ack) begin
                bus.i_req  = gen && ($urandom_range(0, 2) != 0);
                bus.i_addr = {55'd0, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 2'b00};
            end
            if (!bus.d_req || bus.d_ack) begin
                bus.d_req   = gen && ($urandom_range(0, 2) != 0);
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = {55'd0, 6'($urandom_range(0, 63)),
                               ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000};
                bus.d_wdata = {$urandom, $urandom};
            end
        end
        chkb("drain_idle", bus.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
